// File: rtl/avg_sequencer.sv
// AVG vector engine instruction sequencer: fetches instruction windows, walks the display list, hands draws to the beam generator.
// Optional build macro AVG_WATCHDOG_EN adds a per-list instruction limit (MAX_INST) and the sticky wdog_trip output.
module avg_sequencer #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [15:0] START_ADDR  = 16'h0000,
  parameter int unsigned MAX_INST    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  output logic [31:0] inst,
  output logic        dcd_valid,
  input  logic [2:0]  pc_offset,
  input  logic        jmp,
  input  logic        jsr,
  input  logic        ret,
  input  logic        halt,
  input  logic        vector,
  input  logic        center,
  input  logic [15:0] jump_addr,
  output logic        draw_req,
  input  logic        draw_done,
  output logic        busy,
  output logic        stack_err
`ifdef AVG_WATCHDOG_EN
  ,
  output logic        wdog_trip
`endif
);

  localparam int unsigned AW    = 16;
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;
  localparam logic [AW-1:0] EVEN_MASK = 16'hFFFE;
  localparam logic [AW-1:0] START_PC  = START_ADDR & EVEN_MASK;

  // Reject parameter sets the stack pointer arithmetic cannot represent.
  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0 || MAX_INST < 1) begin : g_bad_params
    $error("avg_sequencer: STACK_DEPTH must be a power of 2 >= 2 and MAX_INST >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_F1, S_CAP, S_DEC, S_DRAW, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   pc, pc_nxt;
  logic [SP_W-1:0] sp, sp_nxt;
  logic            err_nxt;
  logic            push;
  logic            rd_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [AW-1:0]   seq_pc;
  logic [AW-1:0]   jmp_pc;
  logic [AW-1:0]   pop_pc;
  logic [AW-1:0]   stack [STACK_DEPTH];

`ifdef AVG_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(MAX_INST + 1);
  logic [CNT_W-1:0] wdog_cnt, cnt_nxt;
  logic             trip_nxt;
`endif

  assign seq_pc = (pc + AW'(pc_offset)) & EVEN_MASK;
  assign jmp_pc = jump_addr & EVEN_MASK;
  assign pop_pc = stack[IDX_W'(sp - SP_W'(1))];

  // Next-state, PC/stack bookkeeping and next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    sp_nxt    = sp;
    err_nxt   = stack_err;
    push      = 1'b0;
`ifdef AVG_WATCHDOG_EN
    cnt_nxt   = wdog_cnt;
    trip_nxt  = wdog_trip;
`endif
    case (state)
      S_IDLE: begin
        if (go) begin
          state_nxt = S_F0;
          pc_nxt    = START_PC;
          sp_nxt    = '0;
          err_nxt   = 1'b0;
`ifdef AVG_WATCHDOG_EN
          cnt_nxt   = '0;
          trip_nxt  = 1'b0;
`endif
        end
      end
      S_F0:  state_nxt = S_F1;
      S_F1:  state_nxt = S_CAP;
      S_CAP: state_nxt = S_DEC;
      S_DEC: begin
        if (halt) begin
          state_nxt = S_DONE;
        end else if (jsr) begin
          if (sp == SP_W'(STACK_DEPTH)) begin
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            push      = 1'b1;
            sp_nxt    = sp + SP_W'(1);
            pc_nxt    = jmp_pc;
            state_nxt = S_F0;
          end
        end else if (jmp) begin
          pc_nxt    = jmp_pc;
          state_nxt = S_F0;
        end else if (ret) begin
          if (sp == '0) begin
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            sp_nxt    = sp - SP_W'(1);
            pc_nxt    = pop_pc;
            state_nxt = S_F0;
          end
        end else if (vector || center) begin
          pc_nxt    = seq_pc;
          state_nxt = S_DRAW;
        end else begin
          pc_nxt    = seq_pc;
          state_nxt = S_F0;
        end
`ifdef AVG_WATCHDOG_EN
        // The limit overrides whatever the decoder asked for on this DEC.
        cnt_nxt = wdog_cnt + CNT_W'(1);
        if (wdog_cnt == CNT_W'(MAX_INST - 1)) begin
          state_nxt = S_DONE;
          trip_nxt  = 1'b1;
          push      = 1'b0;
          err_nxt   = stack_err;
          sp_nxt    = sp;
          pc_nxt    = pc;
        end
`endif
      end
      S_DRAW: begin
        if (draw_done) state_nxt = S_F0;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    rd_nxt   = (state_nxt == S_F0) || (state_nxt == S_F1);
    addr_nxt = '0;
    if (state_nxt == S_F0) addr_nxt = pc_nxt;
    else if (state_nxt == S_F1) addr_nxt = pc + AW'(2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= START_PC;
      sp        <= '0;
      stack_err <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      inst      <= '0;
      dcd_valid <= 1'b0;
      draw_req  <= 1'b0;
      busy      <= 1'b0;
`ifdef AVG_WATCHDOG_EN
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      sp        <= sp_nxt;
      stack_err <= err_nxt;
      mem_rd    <= rd_nxt;
      mem_addr  <= addr_nxt;
      dcd_valid <= (state_nxt == S_DEC);
      draw_req  <= (state_nxt == S_DRAW);
      busy      <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      // Read data lands one cycle after the strobe: word@pc in F1, word@pc+2 in CAP.
      if (state == S_F1)  inst[31:16] <= mem_rdata;
      if (state == S_CAP) inst[15:0]  <= mem_rdata;
`ifdef AVG_WATCHDOG_EN
      wdog_cnt  <= cnt_nxt;
      wdog_trip <= trip_nxt;
`endif
    end
  end

  // Return-address stack; sp itself is reset, entries need not be.
  always_ff @(posedge clk) begin
    if (push) stack[sp[IDX_W-1:0]] <= seq_pc;
  end

endmodule

// File: tb/tb_avg_sequencer.sv
// Directed bench for avg_sequencer: vector RAM, a toy decoder and a beam-generator responder around the DUT.
// Opcode in word[15:12]: 0 HALT, 1 STAT, 2 CNTR, 3 SVEC, 4 VCTR(4 bytes), 5 JMP, 6 JSR, 7 RTS; JMP/JSR target = word[11:0]*2.
module tb_avg_sequencer;
  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] START = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, go;
  logic [15:0] mem_addr, mem_rdata, jump_addr;
  logic        mem_rd, dcd_valid, draw_req, draw_done, busy, stack_err;
  logic [31:0] inst;
  logic [2:0]  pc_offset;
  logic        jmp, jsr, ret, halt, vector, center;
`ifdef AVG_WATCHDOG_EN
  logic        wdog_trip;
`endif

  always #5 clk = ~clk;

  avg_sequencer #(.STACK_DEPTH(DEPTH), .START_ADDR(START), .MAX_INST(8)) dut (
    .clk(clk), .rst(rst), .go(go),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .inst(inst), .dcd_valid(dcd_valid),
    .pc_offset(pc_offset), .jmp(jmp), .jsr(jsr), .ret(ret), .halt(halt),
    .vector(vector), .center(center), .jump_addr(jump_addr),
    .draw_req(draw_req), .draw_done(draw_done),
    .busy(busy), .stack_err(stack_err)
`ifdef AVG_WATCHDOG_EN
    , .wdog_trip(wdog_trip)
`endif
  );

  logic [15:0] ram [0:32767];
  always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr[15:1]];

  always_comb begin
    pc_offset = 3'd2;
    jmp = 1'b0; jsr = 1'b0; ret = 1'b0; halt = 1'b0; vector = 1'b0; center = 1'b0;
    jump_addr = {3'b000, inst[27:16], 1'b0};
    case (inst[31:28])
      4'd0: halt = 1'b1;
      4'd2: center = 1'b1;
      4'd3: vector = 1'b1;
      4'd4: begin vector = 1'b1; pc_offset = 3'd4; end
      4'd5: jmp = 1'b1;
      4'd6: begin jsr = 1'b1; jmp = 1'b1; end
      4'd7: ret = 1'b1;
      default: ;
    endcase
  end

  // Beam generator: completes on the draw_delay-th cycle of draw_req.
  int draw_delay = 1;
  int dcnt = 0;
  initial begin
    draw_done = 1'b0;
    forever begin
      @(negedge clk);
      if (draw_req) begin
        dcnt++;
        draw_done = (dcnt == draw_delay);
      end else begin
        dcnt = 0;
        draw_done = 1'b0;
      end
    end
  end

  logic [15:0] fetch_q[$];
  int          busy_cyc, draw_cyc, n_draws;
  logic        prev_dr = 1'b0;
  logic [31:0] last_inst;
  always @(negedge clk) begin
    if (mem_rd) fetch_q.push_back(mem_addr);
    if (busy) busy_cyc++;
    if (draw_req) begin
      draw_cyc++;
      if (!prev_dr) n_draws++;
    end
    prev_dr = draw_req;
    if (dcd_valid) last_inst = inst;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fetch_at(input int i);
    if (i < fetch_q.size()) return {16'h0000, fetch_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clear_ram();
    for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
  endtask

  task automatic run_list(input string name, input int delay);
    bit ok;
    @(posedge clk); #1;
    fetch_q.delete();
    busy_cyc = 0; draw_cyc = 0; n_draws = 0; last_inst = '0;
    draw_delay = delay;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: busy still %0b after 2000 cycles, required 0", name, busy);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
  endtask

  typedef struct {
    string            name;
    logic [3:0][15:0] w;
    int               delay;
    int               exp_busy;
    int               exp_draws;
    int               exp_drcyc;
    logic             exp_err;
    int               exp_nfetch;
    logic [5:0][15:0] exp_fetch;
    logic [31:0]      exp_inst;
  } vec_t;

  vec_t vt[6];

  initial begin
    // Packed arrays list the highest index first: w = {w3,w2,w1,w0}, exp_fetch = {f5..f0}.
    vt[0] = '{"cntr_halt", {16'h0000, 16'hA5A5, 16'h0000, 16'h2000}, 1, 9, 1, 1, 1'b0, 4,
              {16'h0, 16'h0, 16'h0004, 16'h0002, 16'h0002, 16'h0000}, 32'h0000_A5A5};
    vt[1] = '{"svec_wait10", {16'h0000, 16'h0000, 16'h0000, 16'h3000}, 10, 18, 1, 10, 1'b0, 4,
              {16'h0, 16'h0, 16'h0004, 16'h0002, 16'h0002, 16'h0000}, 32'h0000_0000};
    vt[2] = '{"vctr_ofs4", {16'hBEEF, 16'h0000, 16'h1234, 16'h4000}, 3, 11, 1, 3, 1'b0, 4,
              {16'h0, 16'h0, 16'h0006, 16'h0004, 16'h0002, 16'h0000}, 32'h0000_BEEF};
    vt[3] = '{"stat_stat", {16'hC3C3, 16'h0000, 16'h1000, 16'h1000}, 1, 12, 0, 0, 1'b0, 6,
              {16'h0006, 16'h0004, 16'h0004, 16'h0002, 16'h0002, 16'h0000}, 32'h0000_C3C3};
    vt[4] = '{"rts_empty", {16'h0000, 16'h0000, 16'h0000, 16'h7000}, 1, 4, 0, 0, 1'b1, 2,
              {16'h0, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0000}, 32'h7000_0000};
    vt[5] = '{"jmp_fwd", {16'h3000, 16'h2000, 16'h1000, 16'h5004}, 1, 8, 0, 0, 1'b0, 4,
              {16'h0, 16'h0, 16'h000A, 16'h0008, 16'h0002, 16'h0000}, 32'h0000_0000};

    rst = 1'b1; go = 1'b0;
    clear_ram();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_dcd_valid", {31'b0, dcd_valid}, 32'd0);
    chk("rst_draw_req", {31'b0, draw_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stack_err", {31'b0, stack_err}, 32'd0);
    chk("rst_pc", {16'b0, dut.pc}, {16'b0, START});
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      clear_ram();
      for (int k = 0; k < 4; k++) ram[k] = vt[v].w[k];
      run_list(vt[v].name, vt[v].delay);
      chk({vt[v].name, "_busy_cycles"}, busy_cyc, vt[v].exp_busy);
      chk({vt[v].name, "_draws"}, n_draws, vt[v].exp_draws);
      chk({vt[v].name, "_draw_cycles"}, draw_cyc, vt[v].exp_drcyc);
      chk({vt[v].name, "_stack_err"}, {31'b0, stack_err}, {31'b0, vt[v].exp_err});
      chk({vt[v].name, "_nfetch"}, fetch_q.size(), vt[v].exp_nfetch);
      for (int i = 0; i < vt[v].exp_nfetch; i++)
        chk({vt[v].name, "_fetch_addr"}, fetch_at(i), {16'h0000, vt[v].exp_fetch[i]});
      chk({vt[v].name, "_last_inst"}, last_inst, vt[v].exp_inst);
    end

    // Subroutine call and return: 0 JMP 0x10, 0x10 JSR 0x100, 0x100 RTS, 0x12 HALT.
    clear_ram();
    ram[16'h0000 >> 1] = 16'h5008;
    ram[16'h0010 >> 1] = 16'h6080;
    ram[16'h0100 >> 1] = 16'h7000;
    run_list("jsr_rts", 1);
    chk("jsr_rts_fetch0", fetch_at(0), 32'h0000);
    chk("jsr_rts_fetch1", fetch_at(2), 32'h0010);
    chk("jsr_rts_fetch2", fetch_at(4), 32'h0100);
    chk("jsr_rts_fetch3", fetch_at(6), 32'h0012);
    chk("jsr_rts_busy_cycles", busy_cyc, 16);
    chk("jsr_rts_sp", {29'b0, dut.sp}, 32'd0);
    chk("jsr_rts_stack_err", {31'b0, stack_err}, 32'd0);

    // DEPTH+1 nested calls: the fifth JSR (at 0x80) overflows.
    clear_ram();
    ram[16'h0000 >> 1] = 16'h6010;
    ram[16'h0020 >> 1] = 16'h6020;
    ram[16'h0040 >> 1] = 16'h6030;
    ram[16'h0060 >> 1] = 16'h6040;
    ram[16'h0080 >> 1] = 16'h6050;
    ram[16'h00A0 >> 1] = 16'h1000;
    run_list("overflow", 1);
    chk("overflow_stack_err", {31'b0, stack_err}, 32'd1);
    chk("overflow_busy_cycles", busy_cyc, 20);
    chk("overflow_nfetch", fetch_q.size(), 10);
    chk("overflow_last_fetch", fetch_at(8), 32'h0080);
    chk("overflow_busy_low", {31'b0, busy}, 32'd0);

    // A fresh go clears the sticky error.
    clear_ram();
    run_list("err_clear", 1);
    chk("err_clear_stack_err", {31'b0, stack_err}, 32'd0);
    chk("err_clear_busy_cycles", busy_cyc, 4);

    // go during DRAW is ignored; rst during DRAW aborts at once.
    clear_ram();
    ram[0] = 16'h3000;
    draw_delay = 50;
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (draw_req) begin seen = 1'b1; break; end
        @(posedge clk); #1;
      end
      chk("abort_draw_started", {31'b0, seen}, 32'd1);
    end
    repeat (2) @(posedge clk);
    #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    chk("abort_go_ignored_draw", {31'b0, draw_req}, 32'd1);
    chk("abort_go_ignored_rd", {31'b0, mem_rd}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_draw_req", {31'b0, draw_req}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_pc", {16'b0, dut.pc}, {16'b0, START});
    rst = 1'b0;
    draw_delay = 1;

`ifdef AVG_WATCHDOG_EN
    // JMP-to-self trips the limit on the 8th DEC.
    clear_ram();
    ram[0] = 16'h5000;
    run_list("wdog_loop", 1);
    chk("wdog_trip_set", {31'b0, wdog_trip}, 32'd1);
    chk("wdog_busy_cycles", busy_cyc, 32);
    chk("wdog_busy_low", {31'b0, busy}, 32'd0);
    clear_ram();
    run_list("wdog_clear", 1);
    chk("wdog_trip_cleared", {31'b0, wdog_trip}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
